// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer controller.
package timer_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADED  = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int TICK_DIV_DEF    = 10;
  localparam int ALARM_TICKS_DEF = 3;
endpackage

// File: rtl/timer_ctrl_if.sv
// Command / counter-chain signal bundle between the timer controller and its user.
interface timer_ctrl_if;
  logic       start, stop, load, clear;
  logic       timer_zero;
  logic       t_loadn, t_clearn, t_en;
  logic       done, alarm;
  logic [2:0] state_o;

  modport master (
    output start, stop, load, clear, timer_zero,
    input  t_loadn, t_clearn, t_en, done, alarm, state_o
  );
  modport slave (
    input  start, stop, load, clear, timer_zero,
    output t_loadn, t_clearn, t_en, done, alarm, state_o
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while run is high.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic clearn,
  input  logic run,
  input  logic zero_cnt,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = run & last;

  // zero_cnt wins over run so a restart in the same cycle as a tick starts clean
  always_comb begin
    cnt_d = cnt_q;
    if (zero_cnt)  cnt_d = '0;
    else if (run)  cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clearn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: command FSM, load/clear strobes and tick enable.
// Optional alarm window enabled with `define TIMER_ALARM_EN.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
  input  logic         clk,
  input  logic         clearn,
  timer_ctrl_if.slave  bus
);
  state_e state_q, state_d;
  logic   t_loadn_q, t_loadn_d;
  logic   t_clearn_q, t_clearn_d;
  logic   zero_cnt, run, tick;

  always_comb begin
    state_d    = state_q;
    t_loadn_d  = 1'b1;
    t_clearn_d = 1'b1;
    zero_cnt   = 1'b0;
    if (bus.clear) begin
      state_d    = S_IDLE;
      t_clearn_d = 1'b0;
      zero_cnt   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.load) begin
          state_d   = S_LOADED;
          t_loadn_d = 1'b0;
        end
        S_LOADED, S_PAUSED: begin
          if (bus.load) begin
            state_d   = S_LOADED;
            t_loadn_d = 1'b0;
          end else if (bus.start) begin
            state_d  = bus.timer_zero ? S_DONE : S_RUNNING;
            // a fresh run restarts the tick phase; a resume keeps it
            zero_cnt = bus.timer_zero || (state_q == S_LOADED);
          end
        end
        S_RUNNING: begin
          if (bus.timer_zero) begin
            state_d  = S_DONE;
            zero_cnt = 1'b1;
          end else if (bus.stop) begin
            state_d = S_PAUSED;
          end
        end
        S_DONE: if (bus.load) begin
          state_d   = S_LOADED;
          t_loadn_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      state_q    <= S_IDLE;
      t_loadn_q  <= 1'b1;
      t_clearn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_loadn_q  <= t_loadn_d;
      t_clearn_q <= t_clearn_d;
    end
  end

`ifdef TIMER_ALARM_EN
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  logic          alarm_q, alarm_d;
  logic [AW-1:0] acnt_q, acnt_d;

  // prescaler free-runs in DONE so the alarm window is measured in whole ticks
  assign run = (state_q == S_RUNNING) || (state_q == S_DONE);

  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (state_d != S_DONE) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (state_q != S_DONE) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_q && tick) begin
      if (acnt_q == AW'(ALARM_TICKS - 1)) alarm_d = 1'b0;
      else                                acnt_d  = acnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign run       = (state_q == S_RUNNING);
  assign bus.alarm = 1'b0;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk      (clk),
    .clearn   (clearn),
    .run      (run),
    .zero_cnt (zero_cnt),
    .tick     (tick)
  );

  assign bus.t_en     = tick & (state_q == S_RUNNING) & ~bus.timer_zero;
  assign bus.t_loadn  = t_loadn_q;
  assign bus.t_clearn = t_clearn_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.state_o  = state_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with TICK_DIV=4, ALARM_TICKS=2.
module tb_timer_ctrl;
  import timer_pkg::*;

`ifdef TIMER_ALARM_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  localparam logic [3:0] CL = 4'b1000, LD = 4'b0100, SP = 4'b0010, ST = 4'b0001;

  typedef struct packed {
    logic [2:0] st;
    logic       ldn, cln, en, done, alarm;
  } obs_t;

  typedef struct {
    obs_t  e;
    string tag;
  } sb_t;

  logic clk = 1'b0;
  logic clearn = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_if tif ();

  timer_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (tif)
  );

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (st/ldn/cln/en/done/alarm)", tag, got[7:0], exp[7:0]);
    end
  endtask

  function automatic obs_t ex(input state_e s, input logic ldn = 1'b1, input logic cln = 1'b1,
                              input logic en = 1'b0, input logic al = 1'b0);
    obs_t o;
    o.st    = s;
    o.ldn   = ldn;
    o.cln   = cln;
    o.en    = en;
    o.done  = (s == S_DONE);
    o.alarm = al;
    return o;
  endfunction

  // one cycle: drive inputs just after the edge and queue what the outputs must be this cycle
  task automatic cyc(input string tag, input obs_t e, input logic [3:0] cmd = 4'b0,
                     input logic tz = 1'b0, input logic rn = 1'b1);
    sb_t it;
    @(posedge clk);
    #1;
    {tif.clear, tif.load, tif.stop, tif.start} = cmd;
    tif.timer_zero = tz;
    clearn         = rn;
    it.e   = e;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  always @(negedge clk) begin
    sb_t it;
    if (sbq.size() != 0) begin
      it = sbq.pop_front();
      chk(it.tag, {24'd0, tif.state_o, tif.t_loadn, tif.t_clearn, tif.t_en, tif.done, tif.alarm},
          {24'd0, it.e});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    {tif.clear, tif.load, tif.stop, tif.start} = 4'b0;
    tif.timer_zero = 1'b0;
    clearn = 1'b0;

    cyc("rst0", ex(S_IDLE, 1, 0), 0, 0, 0);
    cyc("rst1", ex(S_IDLE, 1, 0), 0, 0, 1);
    cyc("rel",  ex(S_IDLE, 1, 1), LD);
    cyc("ld_strobe", ex(S_LOADED, 0, 1));
    cyc("loaded",    ex(S_LOADED), ST);

    for (int k = 1; k <= 14; k++)
      cyc($sformatf("run%0d", k), ex(S_RUNNING, 1, 1, (k % 4) == 0), (k == 14) ? SP : 4'b0);

    for (int p = 1; p <= 10; p++)
      cyc($sformatf("paused%0d", p), ex(S_PAUSED), (p == 10) ? ST : 4'b0);

    cyc("resume0",    ex(S_RUNNING));
    cyc("resume_ten", ex(S_RUNNING, 1, 1, 1));
    for (int c = 0; c < 3; c++)
      cyc($sformatf("cnt%0d", c), ex(S_RUNNING));
    cyc("tz_no_ten", ex(S_RUNNING, 1, 1, 0), 0, 1);

    for (int d = 1; d <= 10; d++)
      cyc($sformatf("done%0d", d), ex(S_DONE, 1, 1, 0, AEN && d <= 8), (d == 10) ? LD : 4'b0, 1);

    cyc("reload",  ex(S_LOADED, 0, 1));
    cyc("loaded2", ex(S_LOADED), ST, 0);
    cyc("run_a",   ex(S_RUNNING), LD);
    cyc("ld_ign",  ex(S_RUNNING), CL | LD | ST);
    cyc("clr_pri", ex(S_IDLE, 1, 0));
    cyc("clr_rel", ex(S_IDLE), LD);
    cyc("ld3",     ex(S_LOADED, 0, 1));
    cyc("loaded3", ex(S_LOADED), ST, 1);
    cyc("done_direct", ex(S_DONE, 1, 1, 0, AEN), 0, 1);
    cyc("done_hold",   ex(S_DONE, 1, 1, 0, AEN), CL, 1);
    cyc("clr_done",    ex(S_IDLE, 1, 0), LD);
    cyc("ld4",         ex(S_LOADED, 0, 1), ST);
    cyc("run_b1",      ex(S_RUNNING));
    cyc("run_b2",      ex(S_RUNNING), LD | ST, 0, 0);
    cyc("rst_mid",     ex(S_IDLE, 1, 0), 0, 0, 1);
    cyc("rst_mid_rel", ex(S_IDLE));

    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, clock cycles per one-second tick (min 2).
REQ-002 SHALL have parameter ALARM_TICKS, default 3, alarm duration in ticks (min 1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clearn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have ports start, stop, load, clear  input  1 each  level-sampled user commands, active-high.
REQ-006 SHALL have port timer_zero  input  1  zero flag from the min:sec counter chain.
REQ-007 SHALL have port t_loadn  output  1  active-low load strobe to the counter chain.
REQ-008 SHALL have port t_clearn  output  1  active-low clear strobe to the counter chain.
REQ-009 SHALL have port t_en  output  1  count-down enable, one-cycle pulse per tick.
REQ-010 SHALL have ports done  output  1  and alarm  output  1  (completion level; alarm window).
REQ-011 SHALL have port state_o  output  3  current FSM state encoding.

Function
REQ-012 SHALL implement states IDLE=0, LOADED=1, RUNNING=2, PAUSED=3, DONE=4; codes 5-7 SHALL recover to IDLE on next edge.
REQ-013 Command priority SHALL be clear > load > stop > start when asserted in the same cycle.
REQ-014 clear in any state SHALL drive t_clearn=0 for exactly the next cycle, go to IDLE, zero the prescaler, drop done and alarm.
REQ-015 load in IDLE, LOADED, PAUSED or DONE SHALL drive t_loadn=0 for exactly the next cycle and go to LOADED; load in RUNNING SHALL be ignored.
REQ-016 start in LOADED or PAUSED SHALL go to RUNNING when timer_zero=0, else to DONE; start elsewhere SHALL be ignored.
REQ-017 Entering RUNNING from LOADED SHALL zero the prescaler; from PAUSED the prescaler SHALL resume from its held value.
REQ-018 In RUNNING the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-019 t_en SHALL be 1 exactly in cycles where state==RUNNING, prescaler==TICK_DIV-1 and timer_zero==0; first pulse TICK_DIV cycles after entering RUNNING from LOADED.
REQ-020 stop in RUNNING SHALL go to PAUSED next edge; prescaler SHALL hold; no t_en while PAUSED.
REQ-021 timer_zero=1 sampled in RUNNING SHALL go to DONE next edge; t_en SHALL never assert with timer_zero=1.
REQ-022 done SHALL be 1 exactly while state==DONE; DONE SHALL be left only by clear (to IDLE) or load (to LOADED).
REQ-023 t_loadn and t_clearn SHALL never be 0 simultaneously and SHALL idle at 1.

Reset
REQ-024 clearn=0 at an edge SHALL set state IDLE, prescaler 0, t_loadn=1, t_clearn=0 (propagated clear to chain), t_en=0, done=0, alarm=0; t_clearn SHALL return to 1 the first edge after clearn=1.
REQ-025 Reset mid-RUNNING SHALL take effect at the same edge, overriding all commands.

Configuration
REQ-026 With TIMER_ALARM_EN defined, alarm SHALL rise on entry to DONE and stay 1 for ALARM_TICKS x TICK_DIV cycles, then 0 (prescaler free-runs in DONE to time it).
REQ-027 Without TIMER_ALARM_EN, alarm SHALL be constant 0 and no alarm counter logic SHALL be synthesized; all else unchanged.

Structure
REQ-028 State encodings, default TICK_DIV and ALARM_TICKS SHALL live in shared package timer_pkg.
REQ-029 Prescaler SHALL be a sub-module tick_prescaler (ports: clk, clearn, run, zero_cnt, tick).

Verification (TICK_DIV=4, ALARM_TICKS=2)
REQ-030 Reset 2 cycles, release -> state_o=0, t_clearn=0 first cycle then 1, t_en=0, done=0.
REQ-031 load 1 cycle in IDLE -> t_loadn=0 one cycle, state_o=1; start with timer_zero=0 -> state_o=2, t_en pulses at cycles 4, 8, 12 after entry.
REQ-032 stop 1 cycle after prescaler=2 -> PAUSED, no t_en for 10 cycles; start -> first t_en 2 cycles later.
REQ-033 timer_zero=1 in RUNNING -> DONE next edge, done=1, t_en=0; with TIMER_ALARM_EN alarm=1 for 8 cycles; without, alarm=0.
REQ-034 clear+load+start same cycle in RUNNING -> t_clearn=0 one cycle, t_loadn stays 1, state_o=0.
REQ-035 load in RUNNING -> ignored, t_loadn=1; start in LOADED with timer_zero=1 -> DONE directly.
